// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply/divide unit that feeds a register
// file write port directly. It processes one operation at a time and
// retires one bit per clock.
//
// Multiply uses radix-2 shift-add. Divide uses restoring division.
//
// Ports:
//   Clk    - clock; all state updates on the rising edge
//   Clrn   - asynchronous active-low reset
//   Start  - request; only accepted while idle
//   Op     - 00 MUL low word, 01 MULH high word, 10 DIVU quotient, 11 REMU remainder
//   A, B   - operands (A = multiplicand / dividend, B = multiplier / divisor)
//   Rd     - destination register index, captured with Start
//   Flush  - synchronous abort of the operation in flight
//   Busy   - high from acceptance until the completion pulse has ended
//   Done   - one-cycle completion pulse
//   D      - result; holds its value until the next completion
//   Wr     - destination index of the most recently accepted operation
//   We     - register-file write enable (Done and Wr != 0)
//
// Timing: with Start sampled at edge k, WIDTH iterations run on edges
// k+1..k+WIDTH. Edge k+WIDTH+1 selects the result and raises Done.
// The unit is back in IDLE during the Done cycle, so a new Start can be
// accepted at edge k+WIDTH+2.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 5
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Rd,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] D,
    output logic [4:0]       Wr,
    output logic             We
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     d_q, d_d;
    logic [4:0]           wr_q, wr_d;
    logic                 done_q, done_d;
    logic                 we_q, we_d;
    logic                 busy_q, busy_d;

    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH+1:0]     div_shift_s;
    logic [WIDTH+1:0]     div_diff_s;
    logic                 div_borrow_s;
    logic [WIDTH-1:0]     result_s;

    // Datapath for one iteration step and the final result selection.
    always_comb begin
        // The product's low half starts as the multiplier, and its LSB is the
        // current multiplier bit. Add A to the high half if that bit is set.
        // The caller then shifts the whole product right by one.
        if (prod_q[0]) begin
            mul_sum_s = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
        end else begin
            mul_sum_s = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        end

        // Restoring divide. Shift the remainder left, bring in the next
        // dividend MSB (held at the top of quo_q), then trial-subtract.
        // The extra top bit of the difference acts as the borrow.
        div_shift_s  = {rem_q, quo_q[WIDTH-1]};
        div_diff_s   = div_shift_s - {2'b00, b_q};
        div_borrow_s = div_diff_s[WIDTH+1];

        case (op_q)
            2'b00:   result_s = prod_q[WIDTH-1:0];
            2'b01:   result_s = prod_q[2*WIDTH-1:WIDTH];
            2'b10:   result_s = quo_q;
            2'b11:   result_s = rem_q[WIDTH-1:0];
            default: result_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state, iteration and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        d_d     = d_q;
        wr_d    = wr_q;
        done_d  = 1'b0;
        we_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Flush in IDLE changes nothing, but it still blocks a Start
                // in the same cycle.
                if (Flush) begin
                    state_d = S_IDLE;
                end else if (Start) begin
                    state_d = S_RUN;
                    cnt_d   = {CNTW{1'b0}};
                    op_d    = Op;
                    a_d     = A;
                    b_d     = B;
                    wr_d    = Rd;
                    prod_d  = {{WIDTH{1'b0}}, B};
                    rem_d   = {(WIDTH+1){1'b0}};
                    quo_d   = A;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d = {mul_sum_s, prod_q[WIDTH-1:1]};
                    if (div_borrow_s) begin
                        rem_d = div_shift_s[WIDTH:0];
                    end else begin
                        rem_d = div_diff_s[WIDTH:0];
                    end
                    quo_d = {quo_q[WIDTH-2:0], ~div_borrow_s};
                    cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_DONE: begin
                // Flush wins over completion: no pulse, and D stays as it was.
                state_d = S_IDLE;
                if (Flush) begin
                    done_d = 1'b0;
                end else begin
                    done_d = 1'b1;
                    we_d   = (wr_q != 5'd0);
                    d_d    = result_s;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Busy also covers the Done cycle, although the FSM is already idle then.
        busy_d = (state_d != S_IDLE) || done_d;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNTW{1'b0}};
            op_q    <= 2'b00;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            prod_q  <= {(2*WIDTH){1'b0}};
            rem_q   <= {(WIDTH+1){1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            d_q     <= {WIDTH{1'b0}};
            wr_q    <= 5'd0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            d_q     <= d_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign D    = d_q;
    assign Wr   = wr_q;
    assign We   = we_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit.
// Stimulus pushes expected write-back triples into a queue. A monitor pops
// and compares them on every Done pulse. Expected values come from plain
// 64-bit arithmetic.
module tb_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Clrn;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [4:0]  Rd = 5'd0;
    logic        Flush = 1'b0;
    logic        Busy;
    logic        Done;
    logic [31:0] D;
    logic [4:0]  Wr;
    logic        We;

    muldiv_unit #(.WIDTH(32), .CNTW(5)) dut (
        .Clk(Clk), .Clrn(Clrn), .Start(Start), .Op(Op), .A(A), .B(B),
        .Rd(Rd), .Flush(Flush), .Busy(Busy), .Done(Done), .D(D),
        .Wr(Wr), .We(We)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  wr;
        logic        we;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] prev_d = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: unsigned arithmetic; divide by zero yields all ones / dividend.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Returns just after the edge that samples Start.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit push, input bit wait_idle);
        exp_t e;
        int   n;
        n = 0;
        @(negedge Clk);
        if (wait_idle) begin
            while (Busy && n < 200) begin
                @(negedge Clk);
                n++;
            end
            if (Busy) check("idle_timeout", {63'd0, Busy}, 64'd0);
        end
        Op = op; A = a; B = b; Rd = rd; Start = 1'b1;
        if (push) begin
            e.d  = ref_result(op, a, b);
            e.wr = rd;
            e.we = (rd != 5'd0);
            exp_q.push_back(e);
            prev_d = e.d;
        end
        @(posedge Clk);
        #1;
        Start = 1'b0;
        A = $urandom; B = $urandom; Op = 2'($urandom); Rd = 5'($urandom);
    endtask

    // Counts edges after the Start edge until Done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge Clk);
            #1;
            lat++;
        end while (!Done && lat < 200);
    endtask

    // Scoreboard monitor: compare every completion against the queue head.
    always @(negedge Clk) begin
        if (Done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {63'd0, Done}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("D", {32'd0, D}, {32'd0, mon_e.d});
                check("Wr", {59'd0, Wr}, {59'd0, mon_e.wr});
                check("We", {63'd0, We}, {63'd0, mon_e.we});
            end
        end else if (We) begin
            check("we_without_done", {63'd0, We}, 64'd0);
        end
    end

    initial begin
        int lat;
        int nd;
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;

        Clrn = 1'b1;
        #1 Clrn = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_we",   {63'd0, We}, 64'd0);
        check("rst_d",    {32'd0, D}, 64'd0);
        check("rst_wr",   {59'd0, Wr}, 64'd0);
        Clrn = 1'b1;

        // Basic MUL with latency and Busy timing.
        issue(2'b00, 32'd7, 32'd6, 5'd3, 1'b1, 1'b1);
        check("busy_run", {63'd0, Busy}, 64'd1);
        wait_done(lat);
        check("lat_mul", 64'(lat), 64'd33);
        check("mul_7x6", {32'd0, D}, 64'd42);
        check("busy_in_done", {63'd0, Busy}, 64'd1);
        @(posedge Clk);
        #1;
        check("busy_after", {63'd0, Busy}, 64'd0);

        // Corner values with hard-coded results.
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b1);
        wait_done(lat);
        check("mulh_ff", {32'd0, D}, 64'hFFFF_FFFE);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b1);
        wait_done(lat);
        check("mul_ff", {32'd0, D}, 64'd1);
        issue(2'b10, 32'd100, 32'd7, 5'd5, 1'b1, 1'b1);
        wait_done(lat);
        check("divu_100_7", {32'd0, D}, 64'd14);
        issue(2'b11, 32'd100, 32'd7, 5'd5, 1'b1, 1'b1);
        wait_done(lat);
        check("remu_100_7", {32'd0, D}, 64'd2);
        issue(2'b10, 32'd666, 32'd0, 5'd6, 1'b1, 1'b1);
        wait_done(lat);
        check("divu_by0", {32'd0, D}, 64'hFFFF_FFFF);
        check("lat_div0", 64'(lat), 64'd33);
        issue(2'b11, 32'd666, 32'd0, 5'd6, 1'b1, 1'b1);
        wait_done(lat);
        check("remu_by0", {32'd0, D}, 64'd666);

        // A second Start during RUN is ignored.
        issue(2'b00, 32'd3, 32'd5, 5'd4, 1'b1, 1'b1);
        repeat (10) @(posedge Clk);
        #1;
        Start = 1'b1; Op = 2'b10; A = 32'd10; B = 32'd20; Rd = 5'd9;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        wait_done(lat);
        check("lat_ignore", 64'(lat), 64'd22);
        check("mul_3x5", {32'd0, D}, 64'd15);
        check("wr_ignore", {59'd0, Wr}, 64'd4);
        nd = 0;
        repeat (40) begin
            @(posedge Clk);
            #1;
            if (Done) nd++;
        end
        check("single_done", 64'(nd), 64'd0);

        // Rd = 0 completes but does not write.
        issue(2'b00, 32'd9, 32'd9, 5'd0, 1'b1, 1'b1);
        wait_done(lat);
        check("done_rd0", {63'd0, Done}, 64'd1);
        check("we_rd0", {63'd0, We}, 64'd0);

        // Reset mid-operation.
        issue(2'b10, 32'd1000, 32'd7, 5'd5, 1'b0, 1'b1);
        repeat (17) @(posedge Clk);
        #2 Clrn = 1'b0;
        #1;
        check("mrst_busy", {63'd0, Busy}, 64'd0);
        check("mrst_done", {63'd0, Done}, 64'd0);
        check("mrst_we",   {63'd0, We}, 64'd0);
        check("mrst_d",    {32'd0, D}, 64'd0);
        check("mrst_wr",   {59'd0, Wr}, 64'd0);
        @(negedge Clk);
        Clrn = 1'b1;
        prev_d = 32'd0;
        issue(2'b10, 32'd666, 32'd3, 5'd6, 1'b1, 1'b1);
        wait_done(lat);
        check("divu_666_3", {32'd0, D}, 64'd222);

        // Flush during RUN iteration 20.
        issue(2'b00, 32'd123, 32'd456, 5'd7, 1'b0, 1'b1);
        repeat (20) @(posedge Clk);
        #1 Flush = 1'b1;
        @(posedge Clk);
        #1 Flush = 1'b0;
        check("flush_run_busy", {63'd0, Busy}, 64'd0);
        check("flush_run_d", {32'd0, D}, {32'd0, prev_d});
        check("flush_run_wr", {59'd0, Wr}, 64'd7);
        nd = 0;
        repeat (40) begin
            @(posedge Clk);
            #1;
            if (Done) nd++;
        end
        check("flush_run_nodone", 64'(nd), 64'd0);

        // Flush in the DONE state, on the edge that would raise Done.
        issue(2'b10, 32'd50, 32'd5, 5'd8, 1'b0, 1'b1);
        repeat (32) @(posedge Clk);
        #1 Flush = 1'b1;
        @(posedge Clk);
        #1 Flush = 1'b0;
        check("flush_done_done", {63'd0, Done}, 64'd0);
        check("flush_done_we", {63'd0, We}, 64'd0);
        check("flush_done_busy", {63'd0, Busy}, 64'd0);
        check("flush_done_d", {32'd0, D}, {32'd0, prev_d});
        check("flush_done_wr", {59'd0, Wr}, 64'd8);

        // Flush in IDLE blocks a same-cycle Start.
        @(negedge Clk);
        Start = 1'b1; Flush = 1'b1; Op = 2'b00; A = 32'd2; B = 32'd2; Rd = 5'd1;
        @(posedge Clk);
        #1;
        Start = 1'b0; Flush = 1'b0;
        check("flush_idle_block", {63'd0, Busy}, 64'd0);

        // Back-to-back: the next Start is accepted during the Done cycle.
        issue(2'b00, 32'd11, 32'd13, 5'd2, 1'b1, 1'b1);
        repeat (33) @(posedge Clk);
        #1;
        check("b2b_first_done", {63'd0, Done}, 64'd1);
        issue(2'b10, 32'd77, 32'd4, 5'd3, 1'b1, 1'b0);
        wait_done(lat);
        check("lat_b2b", 64'(lat), 64'd33);

        // Randomized operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            case ($urandom_range(0, 3))
                0:       r_b = 32'd0;
                1:       r_b = 32'($urandom_range(1, 16));
                default: r_b = $urandom;
            endcase
            issue(r_op, r_a, r_b, 5'($urandom), 1'b1, 1'b1);
            wait_done(lat);
            check("lat_rand", 64'(lat), 64'd33);
        end

        repeat (5) @(posedge Clk);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
